bus_access_arbiter: RTL and testbench

- Shares one downstream bus port between three masters: read master 1, read master 2 and the write master.
- Grants requests round-robin and routes each granted transaction to the AXI or APB region by address.
- Sequences the target handshake with a timeout, and returns a response to the granted master.
- Sits between the master ports and the AXI/APB bridge mux; replaces the free-running combinational protocol decode with a per-transaction, registered select.

---
 rtl/bus_arb_pkg.sv | 36 +++
 rtl/rr_arbiter3.sv | 46 ++++
 rtl/bus_access_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_bus_access_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus access arbiter: address map, FSM states,
// master identifiers, protocol codes and the round-robin successor helper.
package bus_arb_pkg;

  // Default address map: AXI occupies 0..AXI_END, APB follows up to APB_END.
  localparam logic [31:0] AXI_END = 32'h3FFF_FFFF;
  localparam logic [31:0] APB_END = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Values double as the rsp_id encoding and as the grant vector bit index.
  typedef enum logic [1:0] {
    RD1 = 2'd0,
    RD2 = 2'd1,
    WR  = 2'd2
  } master_id_e;

  typedef enum logic {
    APB = 1'b0,
    AXI = 1'b1
  } protocol_e;

  // Next master in round-robin order, wrapping WR back to RD1.
  function automatic master_id_e next_id(input master_id_e id);
    case (id)
      RD1:     return RD2;
      RD2:     return WR;
      default: return RD1;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter. The pointer names the highest-priority
// master; after an accepted grant the winner drops to lowest priority.
module rr_arbiter3
  import bus_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       accept,
  output logic [2:0] gnt,
  output master_id_e win_id,
  output logic       any_req
);

  master_id_e ptr_q;
  master_id_e cand;
  logic       found;

  // Scan from the pointer upward with wrap-around; first requester wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    win_id = ptr_q;
    cand   = ptr_q;
    found  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!found && req[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
      cand = next_id(cand);
    end
    gnt     = found ? (3'b001 << win_id) : 3'b000;
    any_req = found;
  end

  // Pointer advances past the winner only when the grant is taken.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    if (rst) begin
      ptr_q <= RD1;
    end else if (accept && found) begin
      ptr_q <= next_id(win_id);
    end
  end

endmodule

// File: rtl/bus_access_arbiter.sv
// Shares one downstream target port between two read masters and a write
// master. A winner is chosen round-robin in IDLE, its request is registered
// together with the AXI/APB select, the target handshake runs under a
// timeout in ISSUE, and a one-cycle response is returned in RESP.
module bus_access_arbiter #(
  parameter logic [31:0] AXI_END = bus_arb_pkg::AXI_END,
  parameter logic [31:0] APB_END = bus_arb_pkg::APB_END,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd1_req,
  input  logic        rd2_req,
  input  logic        wr_req,
  input  logic [31:0] M_Raddr1,
  input  logic [31:0] M_Raddr2,
  input  logic [31:0] M_waddr,
  input  logic [31:0] M_wdata,
  output logic        rd1_gnt,
  output logic        rd2_gnt,
  output logic        wr_gnt,
  output logic        tgt_valid,
  output logic        tgt_write,
  output logic [31:0] tgt_addr,
  output logic [31:0] tgt_wdata,
  output logic        protocol_select,
  input  logic        tgt_ready,
  input  logic [31:0] tgt_rdata,
  input  logic        tgt_err,
  output logic        rsp_valid,
  output logic [1:0]  rsp_id,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  import bus_arb_pkg::*;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  master_id_e  owner_q, owner_d;
  logic [7:0]  timer_q, timer_d;
  logic        dec_err_q, dec_err_d;
  logic [2:0]  gnt_q, gnt_d;
  logic        tgt_valid_d, tgt_write_d, protocol_select_d;
  logic [31:0] tgt_addr_d, tgt_wdata_d;
  logic        rsp_valid_d, rsp_err_d;
  master_id_e  rsp_id_q, rsp_id_d;
  logic [31:0] rsp_rdata_d;

  logic [2:0]  req_vec, arb_gnt;
  master_id_e  win_id;
  logic        any_req, arb_accept;
  logic [31:0] win_addr;

  assign req_vec = {wr_req, rd2_req, rd1_req};

  rr_arbiter3 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_vec),
    .accept  (arb_accept),
    .gnt     (arb_gnt),
    .win_id  (win_id),
    .any_req (any_req)
  );

  // Address of whichever master the arbiter currently favours.
  always_comb begin
    case (win_id)
      RD1:     win_addr = M_Raddr1;
      RD2:     win_addr = M_Raddr2;
      default: win_addr = M_waddr;
    endcase
  end

  // Next-state and next-output logic; every register holds unless told otherwise,
  // except the grant and response pulses which default low.
  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    timer_d           = timer_q;
    dec_err_d         = dec_err_q;
    tgt_valid_d       = tgt_valid;
    tgt_write_d       = tgt_write;
    tgt_addr_d        = tgt_addr;
    tgt_wdata_d       = tgt_wdata;
    protocol_select_d = protocol_select;
    gnt_d             = 3'b000;
    rsp_valid_d       = 1'b0;
    rsp_id_d          = RD1;
    rsp_rdata_d       = '0;
    rsp_err_d         = 1'b0;
    arb_accept        = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          arb_accept        = 1'b1;
          owner_d           = win_id;
          gnt_d             = arb_gnt;
          tgt_addr_d        = win_addr;
          tgt_write_d       = (win_id == WR);
          tgt_wdata_d       = (win_id == WR) ? M_wdata : '0;
          protocol_select_d = (win_addr <= AXI_END) ? AXI : APB;
          timer_d           = '0;
          // An unmapped address still spends one ISSUE cycle, with the target
          // left untouched, so its response lands two cycles after the decision
          // like the fastest mapped transaction.
          dec_err_d         = (win_addr > APB_END);
          tgt_valid_d       = (win_addr <= APB_END);
          state_d           = ISSUE;
        end
      end

      ISSUE: begin
        if (dec_err_q) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = owner_q;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else if (tgt_ready) begin
          tgt_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = owner_q;
          rsp_err_d   = tgt_err;
          rsp_rdata_d = (tgt_write || tgt_err) ? '0 : tgt_rdata;
          state_d     = RESP;
        end else if (timer_q == TIMER_LAST) begin
          tgt_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = owner_q;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      RESP: begin
        dec_err_d = 1'b0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      owner_q         <= RD1;
      timer_q         <= '0;
      dec_err_q       <= 1'b0;
      gnt_q           <= 3'b000;
      tgt_valid       <= 1'b0;
      tgt_write       <= 1'b0;
      tgt_addr        <= '0;
      tgt_wdata       <= '0;
      protocol_select <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_id_q        <= RD1;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      timer_q         <= timer_d;
      dec_err_q       <= dec_err_d;
      gnt_q           <= gnt_d;
      tgt_valid       <= tgt_valid_d;
      tgt_write       <= tgt_write_d;
      tgt_addr        <= tgt_addr_d;
      tgt_wdata       <= tgt_wdata_d;
      protocol_select <= protocol_select_d;
      rsp_valid       <= rsp_valid_d;
      rsp_id_q        <= rsp_id_d;
      rsp_rdata       <= rsp_rdata_d;
      rsp_err         <= rsp_err_d;
    end
  end

  assign rd1_gnt = gnt_q[RD1];
  assign rd2_gnt = gnt_q[RD2];
  assign wr_gnt  = gnt_q[WR];
  assign rsp_id  = rsp_id_q;

endmodule

// File: tb/tb_bus_access_arbiter.sv
// Directed bench for bus_access_arbiter: inputs are driven and outputs are
// sampled on the falling clock edge, with hand-computed expectations.
module tb_bus_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd1_req, rd2_req, wr_req;
  logic [31:0] M_Raddr1, M_Raddr2, M_waddr, M_wdata;
  logic        rd1_gnt, rd2_gnt, wr_gnt;
  logic        tgt_valid, tgt_write, protocol_select;
  logic [31:0] tgt_addr, tgt_wdata;
  logic        tgt_ready, tgt_err;
  logic [31:0] tgt_rdata;
  logic        rsp_valid, rsp_err;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  logic [2:0]  fair_gnt   [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [31:0] fair_addr  [4] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0100};
  logic [1:0]  fair_id    [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
  logic [31:0] fair_rdata [4] = '{32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0000_0000, 32'h0BAD_F00D};

  always #5 clk = ~clk;

  bus_access_arbiter #(
    .AXI_END (32'h3FFF_FFFF),
    .APB_END (32'h7FFF_FFFF),
    .TIMEOUT (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rd1_req         (rd1_req),
    .rd2_req         (rd2_req),
    .wr_req          (wr_req),
    .M_Raddr1        (M_Raddr1),
    .M_Raddr2        (M_Raddr2),
    .M_waddr         (M_waddr),
    .M_wdata         (M_wdata),
    .rd1_gnt         (rd1_gnt),
    .rd2_gnt         (rd2_gnt),
    .wr_gnt          (wr_gnt),
    .tgt_valid       (tgt_valid),
    .tgt_write       (tgt_write),
    .tgt_addr        (tgt_addr),
    .tgt_wdata       (tgt_wdata),
    .protocol_select (protocol_select),
    .tgt_ready       (tgt_ready),
    .tgt_rdata       (tgt_rdata),
    .tgt_err         (tgt_err),
    .rsp_valid       (rsp_valid),
    .rsp_id          (rsp_id),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drop_all();
    rd1_req   = 1'b0;
    rd2_req   = 1'b0;
    wr_req    = 1'b0;
    tgt_ready = 1'b0;
    tgt_err   = 1'b0;
    tgt_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int guard;

    rst      = 1'b1;
    M_Raddr1 = '0;
    M_Raddr2 = '0;
    M_waddr  = '0;
    M_wdata  = '0;
    drop_all();
    step();
    step();

    // Reset state
    check("rst_gnt",       {wr_gnt, rd2_gnt, rd1_gnt}, 3'b000);
    check("rst_tgt_valid", tgt_valid, 1'b0);
    check("rst_tgt_addr",  tgt_addr, 32'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_protocol",  protocol_select, 1'b0);
    rst = 1'b0;
    step();

    // Single AXI read from rd1, ready in the first ISSUE cycle
    rd1_req  = 1'b1;
    M_Raddr1 = 32'h0000_1000;
    step();
    check("rd_gnt",       {wr_gnt, rd2_gnt, rd1_gnt}, 3'b001);
    check("rd_tgt_valid", tgt_valid, 1'b1);
    check("rd_tgt_write", tgt_write, 1'b0);
    check("rd_tgt_addr",  tgt_addr, 32'h0000_1000);
    check("rd_protocol",  protocol_select, 1'b1);
    check("rd_no_rsp",    rsp_valid, 1'b0);
    tgt_ready = 1'b1;
    tgt_rdata = 32'hDEAD_BEEF;
    step();
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_rsp_id",    rsp_id, 2'd0);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("rd_rsp_err",   rsp_err, 1'b0);
    check("rd_valid_off", tgt_valid, 1'b0);
    check("rd_gnt_pulse", {wr_gnt, rd2_gnt, rd1_gnt}, 3'b000);
    drop_all();
    step();
    check("rd_rsp_pulse", rsp_valid, 1'b0);

    // APB write from the write master; read data from the target is discarded
    wr_req  = 1'b1;
    M_waddr = 32'h4000_0010;
    M_wdata = 32'h1234_5678;
    step();
    check("wr_gnt",       {wr_gnt, rd2_gnt, rd1_gnt}, 3'b100);
    check("wr_tgt_write", tgt_write, 1'b1);
    check("wr_protocol",  protocol_select, 1'b0);
    check("wr_tgt_wdata", tgt_wdata, 32'h1234_5678);
    check("wr_tgt_addr",  tgt_addr, 32'h4000_0010);
    tgt_ready = 1'b1;
    tgt_rdata = 32'hFFFF_FFFF;
    step();
    check("wr_rsp_valid", rsp_valid, 1'b1);
    check("wr_rsp_id",    rsp_id, 2'd2);
    check("wr_rsp_rdata", rsp_rdata, 32'h0);
    check("wr_rsp_err",   rsp_err, 1'b0);
    drop_all();
    step();

    // Fairness: all three held, ready held; order rd1, rd2, wr, rd1 every 3 cycles
    rd1_req   = 1'b1;
    rd2_req   = 1'b1;
    wr_req    = 1'b1;
    M_Raddr1  = 32'h0000_0100;
    M_Raddr2  = 32'h0000_0200;
    M_waddr   = 32'h0000_0300;
    M_wdata   = 32'hAAAA_5555;
    tgt_ready = 1'b1;
    tgt_rdata = 32'h0BAD_F00D;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("fair%0d_gnt", i),  {wr_gnt, rd2_gnt, rd1_gnt}, fair_gnt[i]);
      check($sformatf("fair%0d_addr", i), tgt_addr, fair_addr[i]);
      step();
      check($sformatf("fair%0d_rsp_valid", i), rsp_valid, 1'b1);
      check($sformatf("fair%0d_rsp_id", i),    rsp_id, fair_id[i]);
      check($sformatf("fair%0d_rsp_rdata", i), rsp_rdata, fair_rdata[i]);
      if (i == 3) drop_all();
      step();
      check($sformatf("fair%0d_idle_gnt", i),   {wr_gnt, rd2_gnt, rd1_gnt}, 3'b000);
      check($sformatf("fair%0d_idle_valid", i), tgt_valid, 1'b0);
    end

    // Decode error from rd2: no target access, response two cycles after the decision
    rd2_req  = 1'b1;
    M_Raddr2 = 32'h8000_0000;
    step();
    check("dec_gnt",       {wr_gnt, rd2_gnt, rd1_gnt}, 3'b010);
    check("dec_tgt_valid", tgt_valid, 1'b0);
    check("dec_no_rsp",    rsp_valid, 1'b0);
    step();
    check("dec_rsp_valid", rsp_valid, 1'b1);
    check("dec_rsp_id",    rsp_id, 2'd1);
    check("dec_rsp_err",   rsp_err, 1'b1);
    check("dec_rsp_rdata", rsp_rdata, 32'h0);
    check("dec_tgt_valid2", tgt_valid, 1'b0);
    drop_all();
    step();

    // Last AXI address, target reports an error: rdata forced to zero
    rd1_req  = 1'b1;
    M_Raddr1 = 32'h3FFF_FFFF;
    step();
    check("axi_end_gnt",      {wr_gnt, rd2_gnt, rd1_gnt}, 3'b001);
    check("axi_end_protocol", protocol_select, 1'b1);
    check("axi_end_valid",    tgt_valid, 1'b1);
    tgt_ready = 1'b1;
    tgt_err   = 1'b1;
    tgt_rdata = 32'h1111_2222;
    step();
    check("axi_end_rsp_err",   rsp_err, 1'b1);
    check("axi_end_rsp_rdata", rsp_rdata, 32'h0);
    drop_all();
    step();

    // Last APB address is still mapped
    rd2_req  = 1'b1;
    M_Raddr2 = 32'h7FFF_FFFF;
    step();
    check("apb_end_gnt",      {wr_gnt, rd2_gnt, rd1_gnt}, 3'b010);
    check("apb_end_protocol", protocol_select, 1'b0);
    check("apb_end_valid",    tgt_valid, 1'b1);
    tgt_ready = 1'b1;
    tgt_rdata = 32'h5555_AAAA;
    step();
    check("apb_end_rsp_id",    rsp_id, 2'd1);
    check("apb_end_rsp_err",   rsp_err, 1'b0);
    check("apb_end_rsp_rdata", rsp_rdata, 32'h5555_AAAA);
    drop_all();
    step();

    // Timeout: no ready, tgt_valid for exactly 16 cycles, then an error response
    wr_req  = 1'b1;
    M_waddr = 32'h0000_2000;
    M_wdata = 32'hCAFE_0001;
    step();
    check("to_gnt", {wr_gnt, rd2_gnt, rd1_gnt}, 3'b100);
    cnt   = 0;
    guard = 0;
    while (tgt_valid === 1'b1 && guard < 40) begin
      cnt++;
      guard++;
      step();
    end
    check("to_valid_cycles", cnt, 16);
    check("to_rsp_valid",    rsp_valid, 1'b1);
    check("to_rsp_err",      rsp_err, 1'b1);
    check("to_rsp_id",       rsp_id, 2'd2);
    check("to_rsp_rdata",    rsp_rdata, 32'h0);
    wr_req    = 1'b0;
    tgt_ready = 1'b1;
    step();
    check("to_late_rsp",   rsp_valid, 1'b0);
    check("to_late_valid", tgt_valid, 1'b0);
    step();
    check("idle_ready_rsp", rsp_valid, 1'b0);
    check("idle_ready_gnt", {wr_gnt, rd2_gnt, rd1_gnt}, 3'b000);
    drop_all();
    step();

    // Reset in ISSUE: outputs clear, no response, pointer returns to rd1
    rd1_req  = 1'b1;
    M_Raddr1 = 32'h0000_3000;
    step();
    check("rmid_gnt",   {wr_gnt, rd2_gnt, rd1_gnt}, 3'b001);
    check("rmid_valid", tgt_valid, 1'b1);
    rst     = 1'b1;
    rd1_req = 1'b0;
    step();
    check("rmid_tgt_valid", tgt_valid, 1'b0);
    check("rmid_tgt_addr",  tgt_addr, 32'h0);
    check("rmid_protocol",  protocol_select, 1'b0);
    check("rmid_rsp_valid", rsp_valid, 1'b0);
    check("rmid_gnt_clr",   {wr_gnt, rd2_gnt, rd1_gnt}, 3'b000);
    rst = 1'b0;
    step();
    check("rmid_no_rsp", rsp_valid, 1'b0);
    rd1_req  = 1'b1;
    rd2_req  = 1'b1;
    M_Raddr2 = 32'h0000_4000;
    step();
    check("rmid_ptr_gnt", {wr_gnt, rd2_gnt, rd1_gnt}, 3'b001);
    tgt_ready = 1'b1;
    tgt_rdata = 32'h0000_00A5;
    step();
    check("rmid_rsp_id",    rsp_id, 2'd0);
    check("rmid_rsp_rdata", rsp_rdata, 32'h0000_00A5);
    drop_all();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
